// File: rtl/lstm_pkg.sv
// Shared defaults and FSM encoding for the LSTM x-vector fetch path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lstm_pkg;

    localparam int LSTM_ADDR_WIDTH = 12;
    localparam int LSTM_DATA_WIDTH = 16;
    localparam int LSTM_STOP       = 371;
    localparam int LSTM_TIMESTEP   = 7;
    localparam int LSTM_STEP_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } lstm_state_e;

endpackage

// File: rtl/lstm_fifo2.sv
// Two-entry register FIFO holding returned x-words with their tags.
// Latency: push visible at the head on the next cycle.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module lstm_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop & (count_q != 2'd0);
    assign do_push = push & ((count_q != 2'd2) | do_pop);

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // State registers; storage is zeroed so the head reads 0 after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
    assign count = count_q;

endmodule

// File: rtl/lstm_x_fetch.sv
// Streams TIMESTEP passes of x-memory words 0..STOP to a valid/ready consumer.
// Latency: 2 cycles from read issue to o_valid; sustains 1 word/cycle.
// Backpressure: reads are issued only while the 2-entry FIFO has room for them.
module lstm_x_fetch
    import lstm_pkg::*;
#(
    parameter int ADDR_WIDTH = LSTM_ADDR_WIDTH,
    parameter int DATA_WIDTH = LSTM_DATA_WIDTH,
    parameter int STOP       = LSTM_STOP,
    parameter int TIMESTEP   = LSTM_TIMESTEP,
    parameter int STEP_WIDTH = LSTM_STEP_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  i_start,
    output logic                  o_mem_rd,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic [STEP_WIDTH-1:0] o_step,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int                    PW        = DATA_WIDTH + 1 + STEP_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_STOP = ADDR_WIDTH'(STOP);
    localparam logic [STEP_WIDTH-1:0] STEP_LAST = STEP_WIDTH'(TIMESTEP - 1);

    lstm_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [STEP_WIDTH-1:0] step_q, step_d;
    logic                  inflight_q, inflight_d;
    logic                  infl_last_q, infl_last_d;
    logic [STEP_WIDTH-1:0] infl_step_q, infl_step_d;

    logic [PW-1:0]         fifo_din, fifo_dout;
    logic                  fifo_full, fifo_empty, fifo_pop;
    logic [1:0]            fifo_count;
    logic [2:0]            occ;
    logic                  issue;

    // A read returns one cycle after issue, so inflight doubles as the push strobe.
    assign fifo_din = {i_mem_data, infl_last_q, infl_step_q};
    assign fifo_pop = o_valid & i_ready;

    lstm_fifo2 #(.WIDTH(PW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Occupancy counts stored plus in-flight words; a same-cycle pop frees a
    // slot, which is what lets the pipe run at one word per cycle.
    assign occ   = 3'(fifo_count) + 3'(inflight_q);
    assign issue = (state_q == FETCH) & en
                 & (occ < (3'd2 + 3'(fifo_pop)))
                 & (~fifo_full | fifo_pop);

    // Next-state: FSM, address/step walk and in-flight tag.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        step_d      = step_q;
        inflight_d  = issue;
        infl_last_d = issue & (addr_q == ADDR_STOP);
        infl_step_d = step_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    addr_d  = '0;
                    step_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (issue) begin
                    if (addr_q == ADDR_STOP) begin
                        addr_d = '0;
                        if (step_q == STEP_LAST) begin
                            state_d = DRAIN;
                        end else begin
                            step_d = step_q + 1'b1;
                        end
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (fifo_empty && !inflight_q) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset also kills any in-flight read so its data is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            step_q      <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            infl_step_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            step_q      <= step_d;
            inflight_q  <= inflight_d;
            infl_last_q <= infl_last_d;
            infl_step_q <= infl_step_d;
        end
    end

    // Outputs are forced low while reset is held.
    assign o_mem_rd   = rst & issue;
    assign o_mem_addr = rst ? addr_q : '0;
    assign o_valid    = rst & ~fifo_empty;
    assign o_data     = rst ? fifo_dout[PW-1 -: DATA_WIDTH] : '0;
    assign o_last     = rst & fifo_dout[STEP_WIDTH];
    assign o_step     = rst ? fifo_dout[STEP_WIDTH-1:0] : '0;
    assign o_busy     = rst & ((state_q == FETCH) | (state_q == DRAIN));
    assign o_done     = rst & (state_q == DONE);

endmodule

// File: tb/tb_lstm_x_fetch.sv
module tb_lstm_x_fetch;

    localparam int AW = 12, DW = 16, SW = 3, STOP = 371, TS = 7;
    localparam int TOTAL = (STOP + 1) * TS;

    logic          clk = 1'b0;
    logic          rst, en, i_start, i_ready;
    logic [DW-1:0] i_mem_data;
    logic          o_mem_rd, o_valid, o_last, o_busy, o_done;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_data;
    logic [SW-1:0] o_step;

    int n_assert = 0;
    int n_fail   = 0;

    lstm_x_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .i_start    (i_start),
        .o_mem_rd   (o_mem_rd),
        .o_mem_addr (o_mem_addr),
        .i_mem_data (i_mem_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_last     (o_last),
        .o_step     (o_step),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 clk = ~clk;

    // Memory model: word = address, one cycle after the strobe; junk otherwise.
    always @(posedge clk) i_mem_data <= o_mem_rd ? DW'(o_mem_addr) : 16'hDEAD;

    // Monitor state
    int cyc = 0, rd_cnt, rd_en0, first_rd, first_vld, words, seq_err, stab_err;
    int done_cnt, rd_since_pop, exp_addr, exp_step;
    int w0_data, w0_step, w371_data, w371_last, w371_step, w372_data, w372_step;
    bit hold_prev;
    logic [DW-1:0] h_data;
    logic          h_last;
    logic [SW-1:0] h_step;

    task automatic clear_mon();
        rd_cnt = 0; rd_en0 = 0; first_rd = -1; first_vld = -1; words = 0;
        seq_err = 0; stab_err = 0; done_cnt = 0; rd_since_pop = 0;
        exp_addr = 0; exp_step = 0; hold_prev = 0;
        w0_data = -1; w0_step = -1; w371_data = -1; w371_last = -1;
        w371_step = -1; w372_data = -1; w372_step = -1;
    endtask

    initial begin
        clear_mon();
        forever begin
            @(negedge clk);
            cyc++;
            if (o_mem_rd) begin
                rd_cnt++;
                if (!en) rd_en0++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (o_valid && first_vld < 0) first_vld = cyc;
            if (hold_prev && (!o_valid || o_data !== h_data || o_last !== h_last || o_step !== h_step))
                stab_err++;
            hold_prev = o_valid && !i_ready;
            h_data = o_data; h_last = o_last; h_step = o_step;
            if (o_valid && i_ready) begin
                rd_since_pop = o_mem_rd ? 1 : 0;
                if (int'(o_data) != exp_addr || int'(o_step) != exp_step ||
                    o_last !== (exp_addr == STOP))
                    seq_err++;
                if (words == 0)        begin w0_data = int'(o_data); w0_step = int'(o_step); end
                if (words == STOP)     begin w371_data = int'(o_data); w371_last = int'(o_last); w371_step = int'(o_step); end
                if (words == STOP + 1) begin w372_data = int'(o_data); w372_step = int'(o_step); end
                words++;
                if (exp_addr == STOP) begin exp_addr = 0; exp_step++; end
                else exp_addr++;
            end else if (o_mem_rd) begin
                rd_since_pop++;
            end
            if (o_done) done_cnt++;
        end
    end

    task automatic start_run();
        clear_mon();
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk); #1;
            if (o_done) begin ok = 1'b1; break; end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; i_start = 1'b0; i_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_assert++; if (o_mem_rd !== 1'b0)   begin n_fail++; $display("FAIL reset_mem_rd got=%b exp=0", o_mem_rd); end
        n_assert++; if (o_mem_addr !== '0)   begin n_fail++; $display("FAIL reset_mem_addr got=%0d exp=0", o_mem_addr); end
        n_assert++; if (o_valid !== 1'b0)    begin n_fail++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        n_assert++; if (o_data !== '0)       begin n_fail++; $display("FAIL reset_data got=%0d exp=0", o_data); end
        n_assert++; if (o_last !== 1'b0)     begin n_fail++; $display("FAIL reset_last got=%b exp=0", o_last); end
        n_assert++; if (o_step !== '0)       begin n_fail++; $display("FAIL reset_step got=%0d exp=0", o_step); end
        n_assert++; if (o_busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        n_assert++; if (o_done !== 1'b0)     begin n_fail++; $display("FAIL reset_done got=%b exp=0", o_done); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_nominal();
        bit ok;
        en = 1'b1; i_ready = 1'b1;
        start_run();
        repeat (100) @(posedge clk);
        #1;
        n_assert++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL nom_busy got=%b exp=1", o_busy); end
        wait_done(4000, ok);
        n_assert++; if (!ok)                   begin n_fail++; $display("FAIL nom_timeout got=no_done exp=done"); end
        n_assert++; if (words != TOTAL)        begin n_fail++; $display("FAIL nom_words got=%0d exp=%0d", words, TOTAL); end
        n_assert++; if (seq_err != 0)          begin n_fail++; $display("FAIL nom_sequence got=%0d errors exp=0", seq_err); end
        n_assert++; if (done_cnt != 1)         begin n_fail++; $display("FAIL nom_done_pulses got=%0d exp=1", done_cnt); end
        n_assert++; if (first_vld - first_rd != 2) begin n_fail++; $display("FAIL nom_latency got=%0d exp=2", first_vld - first_rd); end
        n_assert++; if (w371_data != 371)      begin n_fail++; $display("FAIL wrap_data got=%0d exp=371", w371_data); end
        n_assert++; if (w371_last != 1)        begin n_fail++; $display("FAIL wrap_last got=%0d exp=1", w371_last); end
        n_assert++; if (w371_step != 0)        begin n_fail++; $display("FAIL wrap_step got=%0d exp=0", w371_step); end
        n_assert++; if (w372_data != 0)        begin n_fail++; $display("FAIL wrap_next_data got=%0d exp=0", w372_data); end
        n_assert++; if (w372_step != 1)        begin n_fail++; $display("FAIL wrap_next_step got=%0d exp=1", w372_step); end
        n_assert++; if (o_busy !== 1'b0)       begin n_fail++; $display("FAIL nom_idle_busy got=%b exp=0", o_busy); end
        n_assert++; if (o_valid !== 1'b0)      begin n_fail++; $display("FAIL nom_idle_valid got=%b exp=0", o_valid); end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit hit;
        int stall_rd;
        en = 1'b1; i_ready = 1'b1;
        start_run();
        hit = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            if (exp_step == 3 && exp_addr >= 100) begin hit = 1'b1; break; end
        end
        n_assert++; if (!hit) begin n_fail++; $display("FAIL bp_reach_step3 got=timeout exp=reached"); end
        i_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        stall_rd = rd_since_pop;
        n_assert++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held got=%b exp=1", o_valid); end
        n_assert++; if (stall_rd > 2)     begin n_fail++; $display("FAIL bp_reads_past_pop got=%0d exp<=2", stall_rd); end
        i_ready = 1'b1;
        wait_done(4000, ok);
        n_assert++; if (!ok)            begin n_fail++; $display("FAIL bp_timeout got=no_done exp=done"); end
        n_assert++; if (stab_err != 0)  begin n_fail++; $display("FAIL bp_stable got=%0d changes exp=0", stab_err); end
        n_assert++; if (words != TOTAL) begin n_fail++; $display("FAIL bp_words got=%0d exp=%0d", words, TOTAL); end
        n_assert++; if (seq_err != 0)   begin n_fail++; $display("FAIL bp_sequence got=%0d errors exp=0", seq_err); end
    endtask

    task automatic test_en_toggle();
        bit ok;
        en = 1'b1; i_ready = 1'b1;
        start_run();
        ok = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            @(posedge clk); #1;
            if (o_done) begin ok = 1'b1; break; end
            en = ~en;
        end
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_assert++; if (!ok)             begin n_fail++; $display("FAIL en_timeout got=no_done exp=done"); end
        n_assert++; if (rd_en0 != 0)     begin n_fail++; $display("FAIL en_gated_reads got=%0d exp=0", rd_en0); end
        n_assert++; if (rd_cnt != TOTAL) begin n_fail++; $display("FAIL en_read_count got=%0d exp=%0d", rd_cnt, TOTAL); end
        n_assert++; if (words != TOTAL)  begin n_fail++; $display("FAIL en_words got=%0d exp=%0d", words, TOTAL); end
        n_assert++; if (seq_err != 0)    begin n_fail++; $display("FAIL en_sequence got=%0d errors exp=0", seq_err); end
        n_assert++; if (done_cnt != 1)   begin n_fail++; $display("FAIL en_done_pulses got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit hit;
        en = 1'b1; i_ready = 1'b1;
        start_run();
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (words >= 500) begin hit = 1'b1; break; end
        end
        n_assert++; if (!hit) begin n_fail++; $display("FAIL rm_reach_500 got=timeout exp=reached"); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_assert++; if (o_valid !== 1'b0)  begin n_fail++; $display("FAIL rm_valid got=%b exp=0", o_valid); end
        n_assert++; if (o_mem_rd !== 1'b0) begin n_fail++; $display("FAIL rm_mem_rd got=%b exp=0", o_mem_rd); end
        n_assert++; if (o_mem_addr !== '0) begin n_fail++; $display("FAIL rm_mem_addr got=%0d exp=0", o_mem_addr); end
        n_assert++; if (o_data !== '0)     begin n_fail++; $display("FAIL rm_data got=%0d exp=0", o_data); end
        n_assert++; if (o_busy !== 1'b0)   begin n_fail++; $display("FAIL rm_busy got=%b exp=0", o_busy); end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_assert++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rm_dropped_read got=%b exp=0", o_valid); end
        n_assert++; if (o_busy !== 1'b0)  begin n_fail++; $display("FAIL rm_idle got=%b exp=0", o_busy); end
        start_run();
        wait_done(4000, ok);
        n_assert++; if (!ok)            begin n_fail++; $display("FAIL rm_timeout got=no_done exp=done"); end
        n_assert++; if (w0_data != 0 || w0_step != 0) begin n_fail++; $display("FAIL rm_restart got=%0d/%0d exp=0/0", w0_data, w0_step); end
        n_assert++; if (words != TOTAL) begin n_fail++; $display("FAIL rm_words got=%0d exp=%0d", words, TOTAL); end
        n_assert++; if (seq_err != 0)   begin n_fail++; $display("FAIL rm_sequence got=%0d errors exp=0", seq_err); end
    endtask

    task automatic test_spurious_start();
        bit ok;
        en = 1'b1; i_ready = 1'b1;
        start_run();
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            i_start = o_busy;
            if (o_done) begin ok = 1'b1; break; end
        end
        i_start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        n_assert++; if (!ok)             begin n_fail++; $display("FAIL ss_timeout got=no_done exp=done"); end
        n_assert++; if (done_cnt != 1)   begin n_fail++; $display("FAIL ss_done_pulses got=%0d exp=1", done_cnt); end
        n_assert++; if (words != TOTAL)  begin n_fail++; $display("FAIL ss_words got=%0d exp=%0d", words, TOTAL); end
        n_assert++; if (seq_err != 0)    begin n_fail++; $display("FAIL ss_sequence got=%0d errors exp=0", seq_err); end
        n_assert++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL ss_idle got=%b exp=0", o_busy); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_en_toggle();
        test_reset_mid();
        test_spurious_start();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lstm_x_fetch.md
LSTM_X_FETCH -- requirements
Module: lstm_x_fetch

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: x-memory address width.
REQ-002 Parameter DATA_WIDTH, default 16: x-memory word width.
REQ-003 Parameter STOP, default 371: last address of one timestep; each step spans STOP+1 words.
REQ-004 Parameter TIMESTEP, default 7: number of timesteps per run.
REQ-005 Parameter STEP_WIDTH, default 3: width of the step index; it SHALL satisfy 2^STEP_WIDTH >= TIMESTEP.
REQ-006 Port clk  in  1: single clock; all logic on its rising edge.
REQ-007 Port rst  in  1: reset; synchronous, active-low (0 = reset).
REQ-008 Port en  in  1: issue enable; when 0, no new memory reads are issued.
REQ-009 Port i_start  in  1: one-cycle run request.
REQ-010 Port o_mem_rd  out  1: x-memory read strobe.
REQ-011 Port o_mem_addr  out  ADDR_WIDTH: x-memory read address.
REQ-012 Port i_mem_data  in  DATA_WIDTH: read data, valid exactly 1 cycle after o_mem_rd.
REQ-013 Port o_valid  out  1: output word valid.
REQ-014 Port i_ready  in  1: downstream accepts the word.
REQ-015 Port o_data  out  DATA_WIDTH: output word.
REQ-016 Port o_last  out  1: word is the address-STOP word of its step.
REQ-017 Port o_step  out  STEP_WIDTH: timestep index of the word.
REQ-018 Port o_busy  out  1: run in progress.
REQ-019 Port o_done  out  1: one-cycle pulse at end of run.

Function
REQ-020 FSM states SHALL be IDLE, FETCH, DRAIN and DONE.
REQ-021 In IDLE, i_start=1 SHALL load addr=0 and step=0, then enter FETCH; i_start is ignored in all other states.
REQ-022 A read SHALL issue in FETCH only when en=1 and fifo_count + inflight < 2, with inflight in {0,1}.
REQ-023 On each issue: o_mem_rd=1 and o_mem_addr=addr for that cycle.
- If addr != STOP: addr increments by 1.
- If addr == STOP: addr wraps to 0 and step increments.
REQ-024 The issue with addr==STOP and step==TIMESTEP-1 SHALL be the final issue, and the FSM SHALL enter DRAIN.
REQ-025 One cycle after each issue, {i_mem_data, last flag, step} SHALL be pushed into a 2-entry FIFO; the last flag is 1 iff the issued addr was STOP.
REQ-026 o_valid SHALL equal FIFO not-empty; o_data, o_last and o_step SHALL show the FIFO head.
- A pop occurs on o_valid & i_ready.
- Push and pop in the same cycle SHALL both take effect and leave the count unchanged.
REQ-027 Output data SHALL hold stable while o_valid=1 and i_ready=0.
REQ-028 Minimum latency from issue to o_valid SHALL be 2 cycles, giving sustained 1 word/cycle when i_ready=1 and en=1.
REQ-029 In DRAIN, the FSM SHALL go to DONE when the FIFO is empty and inflight==0.
REQ-030 DONE SHALL last one cycle, assert o_done=1, then return to IDLE.
REQ-031 o_busy SHALL be 1 in FETCH and DRAIN, and 0 in IDLE and DONE.
REQ-032 Total words per run SHALL be (STOP+1)*TIMESTEP: 2604 at defaults, in address order, with no loss or duplication under any en/i_ready pattern.
REQ-033 en=0 SHALL not cancel an in-flight read; its data is still pushed.
REQ-034 Address and step counters SHALL be sized to their parameters and SHALL never exceed STOP or TIMESTEP-1.

Reset
REQ-035 While rst=0 at a clock edge, the block SHALL enter IDLE and clear addr, step, inflight and the FIFO.
REQ-036 During reset, all outputs SHALL be 0: o_mem_rd, o_mem_addr, o_valid, o_data, o_last, o_step, o_busy and o_done.
REQ-037 Reset mid-run SHALL discard all pending data; a read returning after reset SHALL be dropped.

Structure
REQ-038 ADDR_WIDTH, DATA_WIDTH, STOP, TIMESTEP and STEP_WIDTH defaults and the FSM state encoding SHALL live in the shared lstm package.
REQ-039 The 2-entry FIFO SHALL be a sub-module named lstm_fifo2, parameterised by width.
- Payload: DATA_WIDTH + 1 + STEP_WIDTH bits.
- Ports: push, pop, full, empty, count.

Verification
REQ-040 Nominal run: i_start pulse, en=1, i_ready=1, memory word = address.
- o_valid first rises 2 cycles after the first o_mem_rd.
- Output is 2604 words, each step 0..371, o_last on every 372nd word.
- o_step runs 0..6; o_done pulses once.
REQ-041 Backpressure: i_ready=0 for 10 cycles mid-step 3.
- At most 2 reads issue beyond the last pop.
- o_data is stable throughout; no word is lost when i_ready returns.
REQ-042 Issue gating: en toggles 0/1 every cycle.
- Reads issue only on en=1.
- Word sequence is identical to REQ-040; the final count is 2604.
REQ-043 Wrap boundary: on the word with addr=371 at step 0 -> o_last=1, o_step=0; the next word has address 0, o_step=1.
REQ-044 Reset mid-operation: rst=0 for 1 cycle at word 500.
- All outputs are 0 next cycle; FSM is IDLE.
- A fresh i_start restarts at addr 0, step 0.
REQ-045 Spurious start: i_start asserted during FETCH and DRAIN is ignored, and exactly one o_done pulse occurs per accepted run.
